// File: rtl/sra_datapath.sv
// sra_datapath -- register-file datapath for a controller-sequenced
// sqrt(x^2+y^2) approximation. Two 8x8 register files, an add/sub ALU,
// a max/min/shift ALU, an R3 accumulator and a registered output port,
// all joined by a wired-OR source bus selected one-hot by trictrl.
// The block has no sequencing of its own; the controller drives every step.
// Optional build macro: SRA_CONTENTION_CHECK_EN enables the sticky bus_err
// contention detector (otherwise bus_err is tied low).
module sra_datapath (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       WER1,
    input  logic [2:0] WAR1,
    input  logic       RER1,
    input  logic [2:0] RAR1,
    input  logic       WER2,
    input  logic [2:0] WAR2,
    input  logic       RER2,
    input  logic [2:0] RAR2,
    input  logic       ALU1,
    input  logic [1:0] ALU2,
    input  logic       WER3,
    input  logic       RR3,
    input  logic       OE,
    input  logic [7:0] trictrl,
    input  logic       done,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       ready,
    output logic       bus_err
);

    logic [7:0] r_rf1 [0:7];
    logic [7:0] r_rf2 [0:7];
    logic [7:0] r_r3;
    logic [7:0] r_dout;
    logic       r_dout_valid;
    logic       r_ready;
    logic       r_run;

    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [7:0] w_alu1;
    logic [7:0] w_alu2;
    logic [7:0] w_bus;

    // Reset-release qualifier: the edge on which reset is seen released only
    // arms this flag, so no register can be written on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // Operand A from RF1 (old contents on a same-cycle write; reads are comb).
    always_comb begin
        w_a = RER1 ? r_rf1[RAR1] : 8'd0;
    end

    // Operand B: R3 takes priority over RF2.
    always_comb begin
        if (RR3)       w_b = r_r3;
        else if (RER2) w_b = r_rf2[RAR2];
        else           w_b = 8'd0;
    end

    // ALU1: add/subtract, naturally modulo 256 at 8 bits.
    always_comb begin
        w_alu1 = ALU1 ? (w_a - w_b) : (w_a + w_b);
    end

    // ALU2: unsigned max/min and the two fixed right shifts of A.
    always_comb begin
        case (ALU2)
            2'b00:   w_alu2 = (w_a >= w_b) ? w_a : w_b;
            2'b01:   w_alu2 = (w_a <= w_b) ? w_a : w_b;
            2'b10:   w_alu2 = w_a >> 1;
            default: w_alu2 = w_a >> 3;
        endcase
    end

    // Wired-OR bus: no select gives 0, multiple selects OR together.
    // trictrl[7:6] are reserved and never drive the bus.
    always_comb begin
        w_bus = ({8{trictrl[0]}} & din)
              | ({8{trictrl[1]}} & w_a)
              | ({8{trictrl[2]}} & w_b)
              | ({8{trictrl[3]}} & w_alu1)
              | ({8{trictrl[4]}} & w_alu2)
              | ({8{trictrl[5]}} & r_r3);
    end

    // RF1 write port, fed from the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_rf1[i] <= 8'd0;
        end else if (r_run && WER1) begin
            r_rf1[WAR1] <= w_bus;
        end
    end

    // RF2 write port, fed from the same bus value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_rf2[i] <= 8'd0;
        end else if (r_run && WER2) begin
            r_rf2[WAR2] <= w_bus;
        end
    end

    // R3 accumulator load from the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_r3 <= 8'd0;
        else if (r_run && WER3)  r_r3 <= w_bus;
    end

    // Output port: dout captures the pre-edge R3; valid pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= 8'd0;
            r_dout_valid <= 1'b0;
        end else if (r_run) begin
            if (OE) r_dout <= r_r3;
            r_dout_valid <= OE;
        end
    end

    // ready is done delayed by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_ready <= 1'b0;
        else if (r_run) r_ready <= done;
    end

`ifdef SRA_CONTENTION_CHECK_EN
    logic       r_bus_err;
    logic [5:0] w_src;
    logic       w_contend;

    // Contention: two or more real sources, or any reserved select bit.
    always_comb begin
        w_src     = trictrl[5:0];
        w_contend = ((w_src & (w_src - 6'd1)) != 6'd0) || (trictrl[7:6] != 2'b00);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_bus_err <= 1'b0;
        else if (r_run && w_contend) r_bus_err <= 1'b1;
    end

    assign bus_err = r_bus_err;
`else
    // Reserved select bits have no function without the detector.
    logic w_unused_rsvd;
    assign w_unused_rsvd = &trictrl[7:6];
    assign bus_err       = 1'b0;
`endif

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign ready      = r_ready;

endmodule

// File: doc/sra_datapath.md
SRA_DATAPATH -- requirements
Module: sra_datapath

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din  in  8  unsigned operand input
- WER1/WAR1  in  1/3  RF1 write enable / write address
- RER1/RAR1  in  1/3  RF1 read enable / read address
- WER2/WAR2  in  1/3  RF2 write enable / write address
- RER2/RAR2  in  1/3  RF2 read enable / read address
- ALU1  in  1  0=add, 1=subtract
- ALU2  in  2  00=max, 01=min, 10=A>>1, 11=A>>3
- WER3  in  1  load R3 from bus
- RR3  in  1  substitute R3 for operand B
- OE  in  1  output strobe
- trictrl  in  8  one-hot bus source select
- done  in  1  sequence complete
- dout  out  8  result
- dout_valid  out  1  one-cycle result pulse
- ready  out  1  registered done
- bus_err  out  1  sticky contention flag

Function
REQ-003 RF1 and RF2 SHALL each be 8x8 storage, written from the bus on the rising clk edge when the write enable is 1.
- Reads are combinational.
- A same-cycle read and write to one address SHALL return the old value.
REQ-004 Operand A SHALL be RF1[RAR1] when RER1=1, else 0.
REQ-005 Operand B SHALL be R3 when RR3=1; otherwise RF2[RAR2] when RER2=1; otherwise 0.
REQ-006 ALU1 SHALL compute A+B or A-B modulo 256, combinationally.
REQ-007 ALU2 SHALL compute, unsigned and combinationally:
- 00: max(A,B)
- 01: min(A,B)
- 10: A>>1
- 11: A>>3
REQ-008 Bus sources SHALL be selected by trictrl:
- bit0: din
- bit1: A
- bit2: B
- bit3: ALU1 result
- bit4: ALU2 result
- bit5: R3
- bits 6-7: reserved, drive nothing
REQ-009 With no trictrl bit set, the bus SHALL be 0.
REQ-010 With more than one trictrl bit set, the bus SHALL be the bitwise OR of the selected sources.
REQ-011 R3 SHALL load the bus on the clk edge when WER3=1.
REQ-012 On a clk edge with OE=1, dout SHALL load R3 and dout_valid SHALL be 1 for exactly that following cycle.
- dout holds its value until the next OE.
REQ-013 ready SHALL equal done delayed by one clk cycle.
REQ-014 Latency SHALL be one cycle from control inputs to any register update; there SHALL be no combinational path from controls to dout.
REQ-015 When WER1, WER2 and WER3 are all asserted in the same cycle, all three writes SHALL take the same bus value.
REQ-016 The block SHALL contain no internal state machine; sequencing SHALL be owned entirely by the driving controller.

Reset
REQ-017 Asserting rst_n low SHALL immediately clear the following, at any time including mid-sequence:
- all RF1 and RF2 entries
- R3 and dout
- dout_valid, ready and bus_err
REQ-018 Deassertion SHALL take effect on the next clk edge; no write SHALL occur on the edge that coincides with deassertion.

Configuration
REQ-019 Macro SRA_CONTENTION_CHECK_EN SHALL control contention detection.
- Defined: bus_err SHALL be set on any clk edge where more than one of trictrl[5:0] is 1 or any of trictrl[7:6] is 1. It SHALL stay set until reset.
- Undefined: bus_err SHALL be tied to 0 and no detection logic built.

Verification
REQ-020 The bench SHALL cover:
- Load: din=40, trictrl=0x01, WER1=1 WAR1=0; then din=30, WER2=1 WAR2=0 -> RF1[0]=40, RF2[0]=30.
- Full sqrt approx: max to RF1[1], min to RF2[1], x>>3 via ALU2=11, x-(x>>3) via ALU1=1, y>>1, sum, max with x into R3, OE -> dout=50, dout_valid one cycle.
- Same-address read/write: write 0x55 to RF1[3] while reading RF1[3], which holds 0x12 -> bus shows 0x12 that cycle and 0x55 the next.
- Add wrap: A=200, B=100, ALU1=0, trictrl=0x08, WER3=1 -> R3=44.
- Contention, macro defined: trictrl=0x03 -> bus = din|A and bus_err=1 sticky; macro undefined -> bus_err stays 0.
- Reset mid-sequence: rst_n low after R3=50 -> dout, R3, dout_valid and ready are 0 immediately, and RF reads return 0.
